// File: rtl/cic_decimator.sv
// N-stage CIC decimator: integrators at the input rate, a one-shot comb pipeline per
// decimation tick, then round-half-up scaling and saturation to the output width.
module cic_decimator #(
    parameter int IN_W   = 12,
    parameter int OUT_W  = 8,
    parameter int N      = 3,
    parameter int R_LOG2 = 12
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic signed [IN_W-1:0]  d_in,
    output logic signed [OUT_W-1:0] d_out,
    output logic                    out_valid
);

    localparam int ACC_W = IN_W + N * R_LOG2;
    localparam int SH    = ACC_W - OUT_W;

    localparam logic signed [ACC_W:0] RND_HALF =
        {{(ACC_W + 1 - SH){1'b0}}, 1'b1, {(SH - 1){1'b0}}};
    localparam logic signed [ACC_W:0] Q_MAX =
        $signed((ACC_W + 1)'((1 << (OUT_W - 1)) - 1));
    localparam logic signed [ACC_W:0] Q_MIN = ~Q_MAX;

    logic signed [ACC_W-1:0] d_ext;
    logic signed [ACC_W-1:0] integ      [N];
    logic signed [ACC_W-1:0] integ_next [N];
    logic signed [ACC_W-1:0] dly        [N];
    logic signed [ACC_W-1:0] comb       [N];
    logic signed [ACC_W-1:0] comb_in    [N];
    logic        [N-1:0]     stage_go;
    logic        [N-1:0]     stg;
    logic        [R_LOG2-1:0] cnt;
    logic                    tick;
    logic signed [ACC_W:0]   rnd;
    logic signed [ACC_W:0]   q_full;
    logic        [OUT_W-1:0] sat_val;

    assign d_ext = {{(ACC_W - IN_W){d_in[IN_W-1]}}, d_in};
    assign tick  = en && (cnt == {R_LOG2{1'b1}});

    // Register chain: every stage sums the previous stage's old value.
    always_comb begin
        integ_next[0] = integ[0] + d_ext;
        for (int k = 1; k < N; k++) begin
            integ_next[k] = integ[k] + integ[k-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N; k++) begin
                integ[k] <= '0;
            end
        end else if (en) begin
            for (int k = 0; k < N; k++) begin
                integ[k] <= integ_next[k];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + R_LOG2'(1);
        end
    end

    // The first comb stage sees the last integrator including this tick's update.
    always_comb begin
        comb_in[0]  = integ_next[N-1];
        stage_go[0] = tick;
        for (int k = 1; k < N; k++) begin
            comb_in[k]  = comb[k-1];
            stage_go[k] = stg[k-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N; k++) begin
                comb[k] <= '0;
                dly[k]  <= '0;
            end
            stg <= '0;
        end else begin
            for (int k = 0; k < N; k++) begin
                if (stage_go[k]) begin
                    comb[k] <= comb_in[k] - dly[k];
                    dly[k]  <= comb_in[k];
                end
            end
            stg <= stage_go;
        end
    end

    // One guard bit keeps the rounding add from wrapping at the positive limit.
    always_comb begin
        rnd    = {comb[N-1][ACC_W-1], comb[N-1]} + RND_HALF;
        q_full = rnd >>> SH;
        if (q_full > Q_MAX) begin
            sat_val = {1'b0, {(OUT_W - 1){1'b1}}};
        end else if (q_full < Q_MIN) begin
            sat_val = {1'b1, {(OUT_W - 1){1'b0}}};
        end else begin
            sat_val = q_full[OUT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_out     <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= stg[N-1];
            if (stg[N-1]) begin
                d_out <= sat_val;
            end
        end
    end

endmodule

// File: tb/tb_cic_decimator.sv
// Directed bench for cic_decimator: the driver predicts each output pulse at its tick,
// and a negedge monitor matches every out_valid against the expected queue.
module tb_cic_decimator;

    localparam int IN_W   = 12;
    localparam int OUT_W  = 8;
    localparam int N      = 3;
    localparam int R_LOG2 = 12;
    localparam int R      = 1 << R_LOG2;
    localparam int LAT    = N + 1;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    en;
    logic signed [IN_W-1:0]  d_in;
    logic signed [OUT_W-1:0] d_out;
    logic                    out_valid;

    int cyc = 0;
    int mcount = 0;
    int checks = 0;
    int fails = 0;

    logic signed [OUT_W-1:0] exp_q[$];
    int                      exp_cyc_q[$];
    bit                      care_q[$];

    cic_decimator #(
        .IN_W(IN_W), .OUT_W(OUT_W), .N(N), .R_LOG2(R_LOG2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .d_in(d_in),
        .d_out(d_out), .out_valid(out_valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // One input cycle; tracks the accepted-sample position independently of the DUT.
    task automatic drive_cycle(input bit e, input logic signed [IN_W-1:0] v, output bit ticked);
        @(posedge clk);
        #1;
        en     = e;
        d_in   = v;
        ticked = 1'b0;
        if (e) begin
            if (mcount == R - 1) begin
                ticked = 1'b1;
                mcount = 0;
            end else begin
                mcount++;
            end
        end
    endtask

    task automatic run_phase(input logic signed [IN_W-1:0] v, input bit toggle,
                             input int n_pulses, input int settle,
                             input int steady_exp, input bit first_care, input int first_exp);
        int  pulses = 0;
        bit  e = 1'b1;
        bit  ticked;
        while (pulses < n_pulses) begin
            drive_cycle(e, v, ticked);
            if (ticked) begin
                exp_cyc_q.push_back(cyc + LAT);
                if (pulses == 0 && first_care) begin
                    exp_q.push_back(OUT_W'(first_exp));
                    care_q.push_back(1'b1);
                end else begin
                    exp_q.push_back(OUT_W'(steady_exp));
                    care_q.push_back(pulses + 1 >= settle);
                end
                pulses++;
            end
            if (toggle) e = ~e;
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", 1, 0);
            end else begin
                logic signed [OUT_W-1:0] ev;
                int ec;
                bit cr;
                ev = exp_q.pop_front();
                ec = exp_cyc_q.pop_front();
                cr = care_q.pop_front();
                check("pulse_cycle", cyc, ec);
                if (cr) check("pulse_value", $signed(d_out), $signed(ev));
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit t;
        rst_n = 1'b0;
        en    = 1'b0;
        d_in  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_d_out", $signed(d_out), 0);
        check("reset_out_valid", int'(out_valid), 0);
        rst_n  = 1'b1;
        mcount = 0;

        // Zero input, then DC steps; 1024 from rest first yields 11, steady 64.
        run_phase(12'sd0,    1'b0, 2, 1, 0,    1'b0, 0);
        run_phase(12'sd1024, 1'b0, 4, 4, 64,   1'b1, 11);
        run_phase(12'sd1024, 1'b1, 2, 1, 64,   1'b0, 0);
        run_phase(12'sd2047, 1'b0, 4, 4, 127,  1'b0, 0);
        run_phase(-12'sd2048, 1'b0, 4, 4, -128, 1'b0, 0);

        // Reset two cycles after the last tick, with the comb pipeline in flight.
        drive_cycle(1'b0, '0, t);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        void'(exp_q.pop_back());
        void'(exp_cyc_q.pop_back());
        void'(care_q.pop_back());
        #1;
        check("midrst_d_out", $signed(d_out), 0);
        check("midrst_out_valid", int'(out_valid), 0);
        repeat (4) begin
            @(negedge clk);
            check("rst_hold_out_valid", int'(out_valid), 0);
        end
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        mcount = 0;
        @(negedge clk);
        check("post_rst_d_out", $signed(d_out), 0);
        run_phase(12'sd1024, 1'b0, 1, 2, 0, 1'b1, 11);

        repeat (LAT + 4) drive_cycle(1'b0, '0, t);
        check("queue_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/cic_decimator.md
CIC_DECIMATOR -- requirements
Module: cic_decimator

Interface
REQ-001 Parameter IN_W, default 12: input sample width, signed two's complement.
REQ-002 Parameter OUT_W, default 8: output sample width, signed two's complement.
REQ-003 Parameter N, default 3: number of integrator stages and number of comb stages.
REQ-004 Parameter R_LOG2, default 12: log2 of the decimation ratio (R = 4096).
REQ-005 Derived ACC_W = IN_W + N*R_LOG2, which is 48 with the defaults; all integrator and comb registers SHALL be ACC_W bits wide.
REQ-006 Port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-007 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-008 Port en, input, 1 bit: input-sample qualifier; high means d_in is valid this cycle.
REQ-009 Port d_in, input, IN_W bits, signed: mixer output sample at the clk rate.
REQ-010 Port d_out, output, OUT_W bits, signed: decimated sample, held between updates; it feeds the HP_IIR stage.
REQ-011 Port out_valid, output, 1 bit: single-cycle strobe, high in the cycle d_out takes a new value.

Function
REQ-012 Integrators: on each cycle with en=1, I1 += sign-extended d_in, and Ik += I(k-1) for k=2..N, using old register values (a register chain). With en=0, all integrators SHALL hold.
REQ-013 Integrator and comb arithmetic SHALL be modular in ACC_W bits; wrap-around is required and SHALL NOT be saturated or flagged.
REQ-014 Decimation counter: R_LOG2 bits, reset to 0, increments on each en=1 cycle, wraps from R-1 to 0, and holds when en=0.
REQ-015 Tick: the cycle with en=1 and counter = R-1; exactly one tick occurs per R accepted samples.
REQ-016 On a tick, comb stage 1 SHALL take IN (its value after that cycle's update) and store the delayed copy D1 <= IN.
REQ-017 Comb pipeline: C1 = IN - D1_old, registered at tick+1; Ck = C(k-1) - Dk_old with Dk <= C(k-1), registered at tick+k; each stage updates exactly once per tick and otherwise holds.
REQ-018 Comb stages SHALL NOT depend on en after the tick; the pipeline SHALL complete even if en drops.
REQ-019 Output stage: at tick+N+1, d_out <= round(CN / 2^(ACC_W-OUT_W)), using round-half-up (add 2^(ACC_W-OUT_W-1) before the arithmetic shift).
REQ-020 Output saturation: results above 2^(OUT_W-1)-1 SHALL clamp to 127, and results below -2^(OUT_W-1) SHALL clamp to -128 (OUT_W=8).
REQ-021 out_valid SHALL be high for exactly the one cycle in which d_out is updated (tick+N+1); it is otherwise low.
REQ-022 Latency from the tick to out_valid SHALL be N+1 = 4 clk cycles.
REQ-023 Ticks are at least R >= N+2 cycles apart, so pipeline overlap cannot occur; R_LOG2 < 3 is unsupported.
REQ-024 DC gain SHALL be R^N = 2^36. A full-scale DC input maps to d_out = d_in / 16 before rounding and saturation.

Reset
REQ-025 While rst_n=0, all integrators, delay registers, comb registers, the counter, and pipeline control SHALL be 0, with d_out=0 and out_valid=0, independent of clk.
REQ-026 Reset asserted mid-operation, including mid comb pipeline, SHALL abort any pending output: no out_valid pulse follows for the aborted tick.
REQ-027 After rst_n deasserts, the first accepted sample SHALL be counter position 0, and the first tick occurs on the R-th accepted sample.

Verification
REQ-028 Reset, then d_in=1024 constant with en=1 -> out_valid pulses every 4096 cycles; from the 4th pulse onward d_out=64.
REQ-029 d_in=2047 constant -> steady d_out=127 (computed 128, saturated); d_in=-2048 constant -> steady d_out=-128.
REQ-030 d_in=0 for 20000 cycles -> every d_out=0; the out_valid spacing is exactly 4096 cycles and each pulse is 1 cycle wide.
REQ-031 en toggling 1/0 every cycle with d_in=1024 -> pulse spacing 8192 cycles, steady d_out=64; integrators hold on en=0 cycles.
REQ-032 Assert rst_n=0 two cycles after a tick (comb pipeline in flight) -> no out_valid for that tick; d_out=0; the next pulse occurs 4096 accepted samples plus 4 cycles after release.
REQ-033 Run d_in=2047 for more than 2^20 decimated periods -> integrators wrap, and d_out stays at 127 with no glitch, confirming modular arithmetic.
